signed_div_pow2_pipe: RTL and testbench
=======================================

SIGNED_DIV_POW2_PIPE -- requirements
Module: signed_div_pow2_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand and result width in bits; legal values are powers of two, 4..64.
REQ-002 The block SHALL have localparam SW = $clog2(N), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream offers a transaction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered transaction this cycle.
REQ-007 The block SHALL have port in_a, input, N bits: two's-complement dividend.
REQ-008 The block SHALL have port in_sh, input, SW bits: exponent k, where the divisor is 2^k and k ranges 0..N-1.
REQ-009 The block SHALL have port in_mode, input, 1 bit: 0 = FLOOR (arithmetic right shift semantics), 1 = TRUNC (signed divide, round toward zero).
REQ-010 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port out_q, output, N bits: two's-complement quotient.

Function
REQ-013 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-014 The pipeline SHALL have two register stages: S1 (bias add) and S2 (shift), each holding a valid bit.
REQ-015 S1 SHALL register the sum = sext(in_a, N+1) + bias, where bias = 2^k - 1 if in_mode=TRUNC and in_a[N-1]=1, else 0; the sum is computed in N+1 bits so that no overflow is possible.
REQ-016 S1 SHALL also register k.
REQ-017 S2 SHALL register the arithmetic right shift of the S1 sum by the registered k, truncated to its low N bits; it drives out_q and out_valid.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid when there is no backpressure.
REQ-019 Throughput SHALL be 1 transaction per cycle while out_ready=1.
REQ-020 S2 SHALL load when !v2 || out_ready.
REQ-021 S1 SHALL load when !v1 || S2 loads.
REQ-022 in_ready SHALL equal the S1 load condition and SHALL be combinational; it SHALL NOT depend on in_valid.
REQ-023 While out_valid=1 and out_ready=0, out_q SHALL stay stable and no data SHALL be lost or duplicated; up to 2 transactions SHALL be held.
REQ-024 Simultaneous input and output transfers on a full pipeline SHALL shift both stages in the same cycle.
REQ-025 Quotients SHALL satisfy TRUNC: q = a / 2^k toward zero, and FLOOR: q = floor(a / 2^k); the result always fits in N bits.
REQ-026 k=0 SHALL return a unchanged in both modes.
REQ-027 in_a = -2^(N-1) SHALL be handled without overflow for every k.
REQ-028 Data registers SHALL update only on stage load; a bubble SHALL clear the valid bit only.

Reset
REQ-029 When rst_n=0 at a clock edge, v1, v2, all data registers and out_q SHALL be cleared to 0.
REQ-030 During reset, in_ready SHALL be driven 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight transactions without emitting them.
REQ-032 The first cycle after reset release SHALL show out_valid=0 and in_ready=1.

Structure
REQ-033 Package signed_div_pow2_pkg SHALL hold the enum div_mode_t {DIV_FLOOR=1'b0, DIV_TRUNC=1'b1}.
REQ-034 Package signed_div_pow2_pkg SHALL hold a function bias_for(a, k, mode) used by both RTL and bench.
REQ-035 There SHALL be one sub-module, pipe_stage_reg #(W): a valid/data register with load enable and synchronous active-low reset, instantiated for S1 and S2.
REQ-036 Shift logic SHALL use a variable arithmetic shift on a signed N+1-bit operand; there SHALL be no divider operator.

Verification
REQ-037 N=8, a=0xF9 (-7), k=1, TRUNC -> out_q=0xFD (-3) exactly 2 cycles later; same stimulus with FLOOR -> 0xFC (-4).
REQ-038 N=8, a=0x80 (-128), k=7: TRUNC -> 0xFF (-1) and FLOOR -> 0xFF; a=0xFF, k=7: TRUNC -> 0x00 and FLOOR -> 0xFF.
REQ-039 Back-to-back stream a=127,-127,64,-1 with k=3, TRUNC and out_ready=1 -> outputs 15, -15, 8, 0 on consecutive cycles, with in_ready held at 1.
REQ-040 out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 transactions accepted, in_ready=0 afterwards, out_q stable; on release, results come out in order with none dropped.
REQ-041 rst_n=0 for 1 cycle with 2 transactions in flight -> next cycle out_valid=0, out_q=0, in_ready=1; neither transaction appears later.
REQ-042 Random 10k transactions with random k, mode and backpressure, checked against a reference model using bias_for from the package -> zero mismatches, order preserved.

Source files
------------

// File: rtl/signed_div_pow2_pkg.sv
// Shared mode encoding and the rounding-bias helper for signed power-of-two division.
package signed_div_pow2_pkg;

  typedef enum logic {
    DIV_FLOOR = 1'b0,
    DIV_TRUNC = 1'b1
  } div_mode_t;

  localparam int MAX_W = 64;

  // Callers sign-extend the dividend to MAX_W bits, so bit MAX_W-1 is always the sign.
  // Adding 2^k-1 to a negative dividend turns the floor of the shift into round-toward-zero.
  function automatic logic [MAX_W:0] bias_for(input logic [MAX_W-1:0] a,
                                              input logic [5:0]       k,
                                              input div_mode_t        mode);
    logic [MAX_W:0] b;
    b = '0;
    if (mode == DIV_TRUNC && a[MAX_W-1])
      b = ((MAX_W+1)'(1) << k) - (MAX_W+1)'(1);
    return b;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus data register; 1 cycle, loads only when i_load.
// A bubble (load with i_vld=0) clears the valid bit and leaves the data untouched.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= i_vld;
      if (i_vld)
        r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/signed_div_pow2_pipe.sv
// Signed divide by 2^k (floor or truncate); 2-cycle latency, 1/cycle throughput.
// Valid/ready both sides; holds up to two results under backpressure, in_ready drops when full.
module signed_div_pow2_pipe
  import signed_div_pow2_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_sh,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_q
);

  localparam int W1 = N + 1;

  logic                 w_s1_load;
  logic                 w_s2_load;
  logic                 r_v1;
  logic                 r_v2;
  logic [W1-1:0]        w_bias;
  logic [W1-1:0]        w_sum;
  logic [SW+W1-1:0]     w_s1_din;
  logic [SW+W1-1:0]     r_s1_dat;
  logic [SW-1:0]        w_s1_k;
  logic signed [W1-1:0] w_s1_sum;
  logic signed [W1-1:0] w_shifted;
  logic [N-1:0]         w_s2_din;
  logic [N-1:0]         r_q;

  assign w_s2_load = !r_v2 || out_ready;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign in_ready  = rst_n && w_s1_load;

  // N+1 bits hold -2^(N-1) plus the largest bias without wrapping.
  assign w_bias   = W1'(bias_for(64'($signed(in_a)), 6'(in_sh), div_mode_t'(in_mode)));
  assign w_sum    = {in_a[N-1], in_a} + w_bias;
  assign w_s1_din = {in_sh, w_sum};

  pipe_stage_reg #(.W(SW + W1)) u_s1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_s1_load),
    .i_vld  (in_valid),
    .i_dat  (w_s1_din),
    .o_vld  (r_v1),
    .o_dat  (r_s1_dat)
  );

  assign {w_s1_k, w_s1_sum} = r_s1_dat;
  assign w_shifted          = w_s1_sum >>> w_s1_k;
  assign w_s2_din           = w_shifted[N-1:0];

  pipe_stage_reg #(.W(N)) u_s2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_s2_load),
    .i_vld  (r_v1),
    .i_dat  (w_s2_din),
    .o_vld  (r_v2),
    .o_dat  (r_q)
  );

  assign out_valid = r_v2;
  assign out_q     = r_q;

endmodule

// File: tb/tb_signed_div_pow2_pipe.sv
// Directed vector table, stream/backpressure/reset sequences, and a random scoreboard run.
module tb_signed_div_pow2_pipe;
  import signed_div_pow2_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [2:0]   in_sh;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  signed_div_pow2_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_sh     (in_sh),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q)
  );

  typedef struct {
    logic [7:0] a;
    logic [2:0] k;
    logic       mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: SV integer division truncates toward zero, >>> floors.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] k, input logic m);
    int ai;
    int r;
    ai = int'($signed(a));
    if (m) r = ai / (1 << k);
    else   r = ai >>> k;
    return r[7:0];
  endfunction

  function automatic logic [7:0] bias_model(input logic [7:0] a, input logic [2:0] k, input logic m);
    int ai;
    int r;
    ai = int'($signed(a));
    r  = (ai + int'(bias_for(64'(ai), 6'(k), div_mode_t'(m)))) >>> k;
    return r[7:0];
  endfunction

  task automatic single(input vec_t v, input int idx);
    in_a = v.a; in_sh = v.k; in_mode = v.mode; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("vec%0d_lat1_valid", idx), 32'(out_valid), 32'd0);
    tick();
    chk($sformatf("vec%0d_lat2_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("vec%0d_q", idx), 32'(out_q), 32'(v.exp));
  endtask

  initial begin
    logic [7:0] s_a[4];
    logic [7:0] s_e[4];
    logic [7:0] b_a[3];
    logic [7:0] b_e[3];
    logic [7:0] qexp[$];
    int acc, got, seen, sent, recv, cyc, bias_bad;
    bit do_in, do_out;

    vecs[0]  = '{8'hF9, 3'd1, 1'b1, 8'hFD};
    vecs[1]  = '{8'hF9, 3'd1, 1'b0, 8'hFC};
    vecs[2]  = '{8'h80, 3'd7, 1'b1, 8'hFF};
    vecs[3]  = '{8'h80, 3'd7, 1'b0, 8'hFF};
    vecs[4]  = '{8'hFF, 3'd7, 1'b1, 8'h00};
    vecs[5]  = '{8'hFF, 3'd7, 1'b0, 8'hFF};
    vecs[6]  = '{8'h05, 3'd0, 1'b1, 8'h05};
    vecs[7]  = '{8'h80, 3'd0, 1'b0, 8'h80};
    vecs[8]  = '{8'h81, 3'd3, 1'b1, 8'hF1};
    vecs[9]  = '{8'h81, 3'd3, 1'b0, 8'hF0};
    vecs[10] = '{8'h80, 3'd1, 1'b1, 8'hC0};
    vecs[11] = '{8'h07, 3'd1, 1'b0, 8'h03};
    vecs[12] = '{8'h7F, 3'd7, 1'b1, 8'h00};
    vecs[13] = '{8'h80, 3'd0, 1'b1, 8'h80};

    // Reset state.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_sh = '0; in_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_out_q", 32'(out_q), 32'd0);

    for (int i = 0; i < 14; i++) single(vecs[i], i);

    // Back-to-back stream, k=3 TRUNC.
    s_a = '{8'h7F, 8'h81, 8'h40, 8'hFF};
    s_e = '{8'h0F, 8'hF1, 8'h08, 8'h00};
    out_ready = 1'b1; in_sh = 3'd3; in_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin in_valid = 1'b1; in_a = s_a[i]; end
      else in_valid = 1'b0;
      #1;
      if (i < 4) chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (i >= 2) begin
        chk($sformatf("stream%0d_valid", i - 2), 32'(out_valid), 32'd1);
        chk($sformatf("stream%0d_q", i - 2), 32'(out_q), 32'(s_e[i - 2]));
      end
      tick();
    end

    // Backpressure: out_ready low for 5 cycles with in_valid held high.
    b_a = '{8'h10, 8'h22, 8'h34};
    b_e = '{8'h08, 8'h11, 8'h1A};
    out_ready = 1'b0; in_sh = 3'd1; in_mode = 1'b0; in_valid = 1'b1;
    acc = 0; in_a = b_a[0];
    for (int i = 0; i < 5; i++) begin
      #1;
      do_in = in_valid && in_ready;
      tick();
      if (do_in) begin acc++; in_a = b_a[acc]; end
      if (i >= 1) chk($sformatf("bp_stable%0d", i), 32'(out_q), 32'(b_e[0]));
    end
    #1;
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        if (got < 2) chk($sformatf("bp_out%0d", got), 32'(out_q), 32'(b_e[got]));
        got++;
      end
      tick();
    end
    chk("bp_out_count", 32'(got), 32'd2);

    // Reset with two transactions in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h55; in_sh = 3'd2; in_mode = 1'b0;
    tick();
    in_a = 8'hAA;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("midrst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_q", 32'(out_q), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_ghosts", 32'(seen), 32'd0);

    // Random traffic with backpressure against the scoreboard.
    sent = 0; recv = 0; cyc = 0; bias_bad = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    while (recv < 10000 && cyc < 60000) begin
      #1;
      do_in  = in_valid && in_ready;
      do_out = out_valid && out_ready;
      if (do_out) begin
        if (qexp.size() == 0) chk("rand_unexpected_out", 32'(out_valid), 32'd0);
        else chk($sformatf("rand_q%0d", recv), 32'(out_q), 32'(qexp.pop_front()));
        recv++;
      end
      if (do_in) begin
        qexp.push_back(model(in_a, in_sh, in_mode));
        if (bias_model(in_a, in_sh, in_mode) != model(in_a, in_sh, in_mode)) bias_bad++;
        sent++;
      end
      tick();
      cyc++;
      if (do_in || !in_valid) begin
        if (sent < 10000 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_a     = 8'($urandom);
          in_sh    = 3'($urandom_range(0, 7));
          in_mode  = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("rand_recv_count", 32'(recv), 32'd10000);
    chk("rand_queue_empty", 32'(qexp.size()), 32'd0);
    chk("rand_bias_vs_div", 32'(bias_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
